// File: rtl/mul_arbiter.sv
// Round-robin front end for one shared iterative multiplier: two requesters hand in
// operand pairs, the core is started once per job, and the product goes back to its owner.
module mul_arbiter #(
   parameter int BITS    = 8,
   parameter int TIMEOUT = 2*BITS+4
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_req0_valid,
   output logic                o_req0_ready,
   input  logic [BITS-1:0]     i_req0_a,
   input  logic [BITS-1:0]     i_req0_b,
   input  logic                i_req1_valid,
   output logic                o_req1_ready,
   input  logic [BITS-1:0]     i_req1_a,
   input  logic [BITS-1:0]     i_req1_b,
   output logic                o_rsp0_valid,
   input  logic                i_rsp0_ready,
   output logic                o_rsp1_valid,
   input  logic                i_rsp1_ready,
   output logic [2*BITS-1:0]   o_rsp_product,
   output logic                o_rsp_error,
   output logic                o_mul_start,
   output logic [BITS-1:0]     o_mul_multiplicand,
   output logic [BITS-1:0]     o_mul_multiplier,
   input  logic                i_mul_finished,
   input  logic [2*BITS-1:0]   i_mul_product,
   output logic                o_busy
);

   localparam int CW = $clog2(TIMEOUT+1);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESPOND} state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_last;
   logic                r_owner;
   logic [BITS-1:0]     r_a;
   logic [BITS-1:0]     r_b;
   logic [CW-1:0]       r_count;
   logic [2*BITS-1:0]   r_product;
   logic                r_error;

   logic                w_grant;
   logic                w_accept;
   logic                w_timeout;
   logic                w_rspReady;

   // On a tie the requester that was not served last wins; ready depends only on valids.
   always_comb begin
      w_grant = i_req1_valid;
      if (i_req0_valid && i_req1_valid) begin
         w_grant = ~r_last;
      end
      w_accept     = (r_state == IDLE) && (i_req0_valid || i_req1_valid);
      o_req0_ready = w_accept && !w_grant;
      o_req1_ready = w_accept && w_grant;
      w_timeout    = (r_count == CW'(TIMEOUT-1));
      w_rspReady   = r_owner ? i_rsp1_ready : i_rsp0_ready;
   end

   always_comb begin
      w_next       = r_state;
      o_mul_start  = 1'b0;
      o_rsp0_valid = 1'b0;
      o_rsp1_valid = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next = START;
            end
         end
         START: begin
            o_mul_start = 1'b1;
            w_next      = WAIT;
         end
         WAIT: begin
            if (i_mul_finished || w_timeout) begin
               w_next = RESPOND;
            end
         end
         RESPOND: begin
            o_rsp0_valid = !r_owner;
            o_rsp1_valid = r_owner;
            if (w_rspReady) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Operands stay put from accept to the next accept; a finished pulse only counts in WAIT.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_last    <= 1'b1;
         r_owner   <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         r_count   <= '0;
         r_product <= '0;
         r_error   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_owner <= w_grant;
                  r_a     <= w_grant ? i_req1_a : i_req0_a;
                  r_b     <= w_grant ? i_req1_b : i_req0_b;
               end
            end
            START: begin
               r_count <= '0;
            end
            WAIT: begin
               r_count <= r_count + 1'b1;
               if (i_mul_finished) begin
                  r_product <= i_mul_product;
                  r_error   <= 1'b0;
               end else if (w_timeout) begin
                  r_product <= '0;
                  r_error   <= 1'b1;
               end
            end
            RESPOND: begin
               if (w_rspReady) begin
                  r_last <= r_owner;
               end
            end
            default: r_count <= '0;
         endcase
      end
   end

   assign o_rsp_product      = r_product;
   assign o_rsp_error        = r_error;
   assign o_mul_multiplicand = r_a;
   assign o_mul_multiplier   = r_b;
   assign o_busy             = (r_state != IDLE);

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Two-port round-robin arbiter and sequencer that shares one iterative multiplier core between two requesters. It accepts operand pairs over valid/ready handshakes and issues a single-cycle start pulse to the core with stable operands. It waits for the core's finished pulse, with a watchdog, and returns the 2*BITS-bit product (or an error) to the owning requester over a valid/ready response channel. It sits between the execution front-end and the shared multiplier core.

## Interface
- BITS, 8, operand width; product width is 2*BITS
- TIMEOUT, 2*BITS+4, max WAIT cycles before the error response; must be ≥ 2
- i_clock  in  1  clock, rising edge
- i_reset  in  1  reset i_reset, synchronous, active-high; clock i_clock
- i_req0_valid / i_req1_valid  in  1  requester N has an operand pair
- o_req0_ready / o_req1_ready  out  1  request N accepted this cycle
- i_req0_a, i_req0_b / i_req1_a, i_req1_b  in  BITS  multiplicand, multiplier of requester N
- o_rsp0_valid / o_rsp1_valid  out  1  response N available
- i_rsp0_ready / i_rsp1_ready  in  1  requester N consumes the response
- o_rsp_product  out  2*BITS  result; shared by both response channels
- o_rsp_error  out  1  1 = timeout, product forced to 0
- o_mul_start  out  1  one-cycle start pulse to the core
- o_mul_multiplicand, o_mul_multiplier  out  BITS  latched operands to the core
- i_mul_finished  in  1  one-cycle completion pulse from the core
- i_mul_product  in  2*BITS  core result, valid while i_mul_finished=1
- o_busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, START, WAIT, RESPOND. Reset → IDLE.
- Arbitration pointer `last`, 1 bit; reset value 1, so requester 0 wins the first tie.
- IDLE:
  - Grant goes to the only valid requester. If both are valid, it goes to the requester != `last`.
  - o_reqN_ready = (state==IDLE) & grant==N. This is combinational from the valids; there is no path from ready back to valid.
  - On the handshake, latch a/b into the operand registers and record `owner`, then go to START.
- START: o_mul_start=1 for exactly this cycle; go to WAIT and clear the watchdog counter.
- WAIT:
  - The counter increments each cycle.
  - If i_mul_finished: capture i_mul_product, set error=0, go to RESPOND.
  - Else if counter==TIMEOUT-1: set product=0, error=1, go to RESPOND.
  - If finished and timeout occur in the same cycle, finished wins.
- RESPOND:
  - o_rsp[owner]_valid=1. Product and error are held stable until i_rsp[owner]_ready=1.
  - On that handshake: `last`<=owner, go to IDLE.
  - The other response valid stays 0.
- Operand registers hold their value from accept until the next accept; the core sees stable operands throughout START and WAIT.
- i_mul_finished outside WAIT (stray or late pulse) is ignored.
- Request valids in any state other than IDLE get ready=0 and no state change.

## Timing
- Reset values: all ready/valid=0, o_mul_start=0, o_busy=0, o_rsp_product=0, o_rsp_error=0, operand outputs=0, `last`=1, counter=0.
- Reset in any state, including mid-WAIT or RESPOND:
  - The in-flight result is dropped.
  - No response is issued.
  - The next cycle is IDLE with reset values.
- Latency, with accept in cycle 0:
  - o_mul_start is high in cycle 1.
  - If the core pulses finished in cycle 1+L, o_rsp valid is high from cycle 2+L.
  - With the standard core (finished BITS cycles after the start cycle), response valid is at cycle BITS+2.
- Throughput: one request per (L+3) cycles minimum, given zero response backpressure. The next accept can occur in the cycle after the response handshake.
- Timeout response valid is at cycle 2+TIMEOUT after accept.

## Test plan
- Single request: req0 a=13, b=11 with a core model using L=BITS=8 → o_req0_ready in cycle 0, start pulse in cycle 1, o_rsp0_valid at cycle 10 with product=143 and error=0; o_rsp1_valid never asserts.
- Tie after reset: both valid, req0 (255,255), req1 (3,5) → req0 served first with product=65025, then req1 with product=15. Ready never asserts for both in the same cycle.
- Fairness: both valids held high for 4 transactions → grant order 0,1,0,1. A lone req1 after that order is granted immediately.
- Backpressure: i_rsp0_ready low for 5 cycles in RESPOND → product and error stable, o_busy=1, req1 held at ready=0. Handshake in cycle 6 → IDLE, and req1 is accepted the next cycle.
- Timeout: core model never asserts finished, TIMEOUT=20 → response at cycle 22 after accept with error=1 and product=0. A late finished pulse afterwards is ignored.
- Reset mid-WAIT: i_reset in cycle 4 after accept → next cycle all outputs at reset values, no response issued. A subsequent req1 (7,9) returns 63.
